multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the RV32I integer core; replaces single-cycle decode with a FETCH/DECODE/EXECUTE/WRITEBACK FSM.
- Drives the datapath strobes: IR load, PC update, regfile write, ALU operand and op select.
- Owns the instruction-memory request handshake, a fetch timeout, and a retired-instruction counter.
- Sits between the imem port and the datapath. It reads opcode/funct3/funct7 from the datapath IR and the ALU zero flag.

Parameters:
- IMEM_TIMEOUT, 16, max FETCH cycles without imem_valid before entering HALT (range 1..255).
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active high
- imem_req  out  1  fetch request, high throughout FETCH
- imem_valid  in  1  instruction word valid this cycle; ignored outside FETCH
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU result == 0
- ir_write  out  1  load IR from imem
- pc_write  out  1  update PC
- pc_src  out  2  00 pc+4, 01 pc+imm, 10 alu_result with bit0 cleared
- regwrite  out  1  write rd
- wb_sel  out  2  00 alu, 01 pc+4, 10 imm (LUI)
- alusrc  out  1  0 rs2, 1 imm
- aluctl  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLTU, 0101 SLT, 0110 XOR, 0111 SLL, 1000 SRL, 1001 SRA
- illegal  out  1  sticky: unsupported encoding decoded
- timeout  out  1  sticky: fetch timeout
- instret  out  RET_W  retired-instruction count
- state_dbg  out  3  current state encoding

Behaviour:
- Reset: clk domain only; synchronous active-high. Next edge forces FETCH, fetch counter 0, zero_q 0, illegal 0, timeout 0, instret 0. While rst is high, every strobe (imem_req, ir_write, pc_write, regwrite) is gated to 0. Reset mid-instruction abandons it with no writes.
- FETCH (000):
  - imem_req=1.
  - imem_valid=1: ir_write=1 that cycle, go to DECODE.
  - Otherwise the fetch counter increments. When it reaches IMEM_TIMEOUT without valid, go to HALT and set timeout.
- DECODE (001):
  - Supported opcodes: 0110011 R, 0010011 I, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI.
  - Any other opcode or illegal funct combination: set illegal, go to HALT.
  - Otherwise go to EXECUTE.
- EXECUTE (010):
  - aluctl/alusrc are valid for the decoded class.
  - zero_q <= zero at the end of the cycle.
  - Always go to WRITEBACK.
- WRITEBACK (011):
  - pc_write=1 and instret+1 (wraps modulo 2^RET_W).
  - R/I: regwrite=1, wb_sel=00, pc_src=00.
  - LUI: regwrite=1, wb_sel=10, pc_src=00.
  - JAL: regwrite=1, wb_sel=01, pc_src=01.
  - JALR: regwrite=1, wb_sel=01, pc_src=10, aluctl=ADD, alusrc=1.
  - BRANCH: regwrite=0. BEQ (funct3 000) takes pc_src=01 iff zero_q=1. BNE (001) takes it iff zero_q=0. Not taken gives pc_src=00.
  - Then go to FETCH.
- HALT (100): all strobes 0; stays until rst.
- aluctl/alusrc hold their decoded value from DECODE through WRITEBACK. In FETCH they are 0010/0.
- ALU decode:
  - R type, funct7 00 or 20 only: 20 is legal only with f3 000 (SUB) and 101 (SRA).
  - I type ignores funct7 except shifts. SLLI requires f7 00. SRLI/SRAI require f7 00/20.
  - SLT=f3 010, SLTU=f3 011.
  - Branch uses SUB, alusrc=0. Branch f3 other than 000/001 is illegal.
  - JAL and LUI use ADD.
- Latency: 4 cycles per instruction when imem_valid arrives in the first FETCH cycle. Each extra wait cycle adds 1.
- Invariants: exactly one pc_write per retired instruction. ir_write only in FETCH. regwrite only in WRITEBACK.

Decomposition:
- Package riscv_ctrl_pkg:
  - opcode localparams
  - funct3/funct7 constants
  - aluctl codes
  - pc_src and wb_sel encodings
  - state encodings
- Sub-module alu_decoder: combinational opcode/funct3/funct7 -> aluctl, alusrc, alu_illegal. Instantiated once; its outputs are registered at the DECODE->EXECUTE transition.

Test Plan:
- Reset, then imem_valid=1 with ADD x3,x1,x2 (f7 00): ir_write in cycle 0; cycle 3 has regwrite=1, wb_sel=00, pc_src=00, aluctl=0010; instret=1 after cycle 3.
- SUB (f7 20, f3 000) then SRAI (0010011, f3 101, f7 20): aluctl 0011 then 1001, alusrc 0 then 1.
- BEQ with zero=1 in EXECUTE: pc_src=01. BNE with zero=1: pc_src=00. Both give regwrite=0 and pc_write=1.
- JALR: pc_src=10, wb_sel=01, alusrc=1, aluctl=0010. LUI: wb_sel=10.
- imem_valid held 0 with IMEM_TIMEOUT=4: after 4 FETCH cycles state=100, timeout=1, imem_req=0. Then rst gives state 000 and flags clear.
- Opcode 0000011: illegal=1, HALT, no regwrite/pc_write. rst asserted during EXECUTE of an ADD: no regwrite, instret unchanged, FETCH next.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencing controller.
// Pure constants and helpers; no latency and no flow control.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_XOR    = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1001;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_IMM = 2'b01;
    localparam logic [1:0] PC_SRC_ALU = 2'b10;

    localparam logic [1:0] WB_ALU     = 2'b00;
    localparam logic [1:0] WB_PC4     = 2'b01;
    localparam logic [1:0] WB_IMM     = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_WRITEBACK = 3'b011,
        ST_HALT      = 3'b100
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU    = 3'd0,
        CL_LUI    = 3'd1,
        CL_JAL    = 3'd2,
        CL_JALR   = 3'd3,
        CL_BRANCH = 3'd4
    } iclass_e;

    // alt selects SUB for f3=000 and SRA for f3=101; callers decide when alt applies.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic is_bne, input logic zero_flag);
        return is_bne ? ~zero_flag : zero_flag;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction-field decode to ALU control, operand select and class.
// Zero latency; no flow control, outputs are sampled by the sequencer in DECODE.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] aluctl,
    output logic       alusrc,
    output logic       alu_illegal,
    output logic [2:0] iclass
);

    logic f7_base;
    logic f7_alt;

    assign f7_base = (funct7 == F7_BASE);
    assign f7_alt  = (funct7 == F7_ALT);

    always_comb begin
        aluctl      = ALU_ADD;
        alusrc      = 1'b0;
        alu_illegal = 1'b0;
        iclass      = CL_ALU;
        case (opcode)
            OPC_R: begin
                aluctl = alu_op(funct3, f7_alt);
                if (f7_alt) begin
                    alu_illegal = !((funct3 == F3_ADD_SUB) || (funct3 == F3_SR));
                end else if (!f7_base) begin
                    alu_illegal = 1'b1;
                end
            end
            OPC_I: begin
                // funct7 only carries meaning for the shift-immediate forms
                alusrc = 1'b1;
                aluctl = alu_op(funct3, (funct3 == F3_SR) && f7_alt);
                if ((funct3 == F3_SLL) && !f7_base) begin
                    alu_illegal = 1'b1;
                end
                if ((funct3 == F3_SR) && !(f7_base || f7_alt)) begin
                    alu_illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                iclass      = CL_BRANCH;
                aluctl      = ALU_SUB;
                alu_illegal = !((funct3 == F3_BEQ) || (funct3 == F3_BNE));
            end
            OPC_JAL: begin
                iclass = CL_JAL;
                alusrc = 1'b1;
            end
            OPC_JALR: begin
                iclass = CL_JALR;
                alusrc = 1'b1;
            end
            OPC_LUI: begin
                iclass = CL_LUI;
                alusrc = 1'b1;
            end
            default: begin
                alu_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXECUTE/WRITEBACK sequencer; 4 cycles per instruction plus imem wait cycles.
// Stalls in FETCH until imem_valid; halts on fetch timeout or illegal encoding until reset.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 16,
    parameter int RET_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_valid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             regwrite,
    output logic [1:0]       wb_sel,
    output logic             alusrc,
    output logic [3:0]       aluctl,
    output logic             illegal,
    output logic             timeout,
    output logic [RET_W-1:0] instret,
    output logic [2:0]       state_dbg
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(IMEM_TIMEOUT);

    state_e           state_q,     state_d;
    logic [7:0]       fetch_cnt_q, fetch_cnt_d;
    logic             zero_q,      zero_d;
    logic             illegal_q,   illegal_d;
    logic             timeout_q,   timeout_d;
    logic [RET_W-1:0] instret_q,   instret_d;
    logic [3:0]       aluctl_q,    aluctl_d;
    logic             alusrc_q,    alusrc_d;
    iclass_e          iclass_q,    iclass_d;
    logic             bne_q,       bne_d;

    logic [3:0] dec_aluctl;
    logic       dec_alusrc;
    logic       dec_illegal;
    logic [2:0] dec_iclass;

    logic imem_req_s;
    logic ir_write_s;
    logic pc_write_s;
    logic regwrite_s;

    alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .aluctl      (dec_aluctl),
        .alusrc      (dec_alusrc),
        .alu_illegal (dec_illegal),
        .iclass      (dec_iclass)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            fetch_cnt_q <= 8'd0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            instret_q   <= '0;
            aluctl_q    <= ALU_ADD;
            alusrc_q    <= 1'b0;
            iclass_q    <= CL_ALU;
            bne_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            instret_q   <= instret_d;
            aluctl_q    <= aluctl_d;
            alusrc_q    <= alusrc_d;
            iclass_q    <= iclass_d;
            bne_q       <= bne_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        instret_d   = instret_q;
        aluctl_d    = aluctl_q;
        alusrc_d    = alusrc_q;
        iclass_d    = iclass_q;
        bne_d       = bne_q;
        imem_req_s  = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        regwrite_s  = 1'b0;
        pc_src      = PC_SRC_SEQ;
        wb_sel      = WB_ALU;
        aluctl      = ALU_ADD;
        alusrc      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                // a valid word on the last allowed cycle still wins over the timeout
                if (imem_valid) begin
                    ir_write_s  = 1'b1;
                    fetch_cnt_d = 8'd0;
                    state_d     = ST_DECODE;
                end else if ((fetch_cnt_q + 8'd1) == TIMEOUT_LIM) begin
                    fetch_cnt_d = 8'd0;
                    timeout_d   = 1'b1;
                    state_d     = ST_HALT;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 8'd1;
                end
            end
            ST_DECODE: begin
                aluctl   = dec_aluctl;
                alusrc   = dec_alusrc;
                aluctl_d = dec_aluctl;
                alusrc_d = dec_alusrc;
                iclass_d = iclass_e'(dec_iclass);
                bne_d    = (funct3 == F3_BNE);
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d   = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                aluctl  = aluctl_q;
                alusrc  = alusrc_q;
                zero_d  = zero;
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                aluctl     = aluctl_q;
                alusrc     = alusrc_q;
                pc_write_s = 1'b1;
                instret_d  = instret_q + RET_W'(1);
                case (iclass_q)
                    CL_LUI: begin
                        regwrite_s = 1'b1;
                        wb_sel     = WB_IMM;
                    end
                    CL_JAL: begin
                        regwrite_s = 1'b1;
                        wb_sel     = WB_PC4;
                        pc_src     = PC_SRC_IMM;
                    end
                    CL_JALR: begin
                        regwrite_s = 1'b1;
                        wb_sel     = WB_PC4;
                        pc_src     = PC_SRC_ALU;
                    end
                    CL_BRANCH: begin
                        pc_src = branch_taken(bne_q, zero_q) ? PC_SRC_IMM : PC_SRC_SEQ;
                    end
                    default: begin
                        regwrite_s = 1'b1;
                    end
                endcase
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Strobes are forced low while reset is held so an abandoned instruction writes nothing.
    assign imem_req  = imem_req_s & ~rst;
    assign ir_write  = ir_write_s & ~rst;
    assign pc_write  = pc_write_s & ~rst;
    assign regwrite  = regwrite_s & ~rst;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign instret   = instret_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table plus WRITEBACK scoreboard.
module tb_multicycle_ctrl;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        logic [3:0] actl;
        logic       asrc;
        logic       rw;
        logic [1:0] wbs;
        logic [1:0] pcs;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic        imem_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        regwrite;
    logic [1:0]  wb_sel;
    logic        alusrc;
    logic [3:0]  aluctl;
    logic        illegal;
    logic        timeout;
    logic [31:0] instret;
    logic [2:0]  state_dbg;

    int   total = 0;
    int   bad   = 0;
    int   instret_exp = 0;
    vec_t sb[$];
    vec_t got;
    vec_t vecs[17];
    vec_t ills[4];

    multicycle_ctrl #(.IMEM_TIMEOUT(4), .RET_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .regwrite   (regwrite),
        .wb_sel     (wb_sel),
        .alusrc     (alusrc),
        .aluctl     (aluctl),
        .illegal    (illegal),
        .timeout    (timeout),
        .instret    (instret),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // WRITEBACK scoreboard and strobe invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (pc_write) begin
            if (sb.size() == 0) begin
                chk("unexpected_pc_write", 32'(pc_write), 32'd0);
            end else begin
                got = sb.pop_front();
                chk("wb_regwrite", 32'(regwrite), 32'(got.rw));
                chk("wb_sel",      32'(wb_sel),   32'(got.wbs));
                chk("wb_pc_src",   32'(pc_src),   32'(got.pcs));
                chk("wb_aluctl",   32'(aluctl),   32'(got.actl));
                chk("wb_alusrc",   32'(alusrc),   32'(got.asrc));
            end
        end
        if (ir_write) chk("ir_write_in_fetch", 32'(state_dbg), 32'd0);
        if (regwrite) chk("regwrite_in_wb",    32'(state_dbg), 32'd3);
    end

    // Entered at posedge+2 with the DUT in FETCH; leaves at posedge+2 after DECODE.
    task automatic to_execute(input vec_t v, input bit push, input int nwait);
        opcode     = v.op;
        funct3     = v.f3;
        funct7     = v.f7;
        zero       = 1'b0;
        imem_valid = 1'b0;
        for (int w = 0; w < nwait; w++) begin
            @(negedge clk);
            chk("wait_in_fetch", 32'(state_dbg), 32'd0);
            @(posedge clk); #2;
        end
        imem_valid = 1'b1;
        if (push) sb.push_back(v);
        @(negedge clk);
        chk("fetch_ir_write", 32'(ir_write), 32'd1);
        chk("fetch_aluctl",   32'(aluctl),   32'h2);
        chk("fetch_alusrc",   32'(alusrc),   32'd0);
        @(posedge clk); #2;
        imem_valid = 1'b0;
        @(negedge clk);
        chk("decode_state", 32'(state_dbg), 32'd1);
        @(posedge clk); #2;
        zero = v.z;
    endtask

    task automatic finish_instr(input vec_t v);
        @(negedge clk);
        chk("exec_state",  32'(state_dbg), 32'd2);
        chk("exec_aluctl", 32'(aluctl),    32'(v.actl));
        chk("exec_alusrc", 32'(alusrc),    32'(v.asrc));
        @(posedge clk); #2;
        zero = ~v.z;
        @(negedge clk);
        chk("wb_state", 32'(state_dbg), 32'd3);
        @(posedge clk); #2;
        instret_exp++;
        chk("instret", instret, 32'(instret_exp));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        instret_exp = 0;
    endtask

    initial begin
        vecs[0]  = '{7'b0110011, 3'b000, 7'h00, 1'b0, 4'b0010, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[1]  = '{7'b0110011, 3'b000, 7'h20, 1'b0, 4'b0011, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[2]  = '{7'b0010011, 3'b101, 7'h20, 1'b0, 4'b1001, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[3]  = '{7'b0110011, 3'b010, 7'h00, 1'b1, 4'b0101, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[4]  = '{7'b0010011, 3'b011, 7'h7f, 1'b0, 4'b0100, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[5]  = '{7'b0110011, 3'b100, 7'h00, 1'b0, 4'b0110, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[6]  = '{7'b0010011, 3'b001, 7'h00, 1'b0, 4'b0111, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[7]  = '{7'b0110011, 3'b101, 7'h00, 1'b0, 4'b1000, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[8]  = '{7'b0010011, 3'b110, 7'h00, 1'b0, 4'b0001, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[9]  = '{7'b0110011, 3'b111, 7'h00, 1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[10] = '{7'b1100011, 3'b000, 7'h00, 1'b1, 4'b0011, 1'b0, 1'b0, 2'b00, 2'b01};
        vecs[11] = '{7'b1100011, 3'b000, 7'h00, 1'b0, 4'b0011, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[12] = '{7'b1100011, 3'b001, 7'h00, 1'b1, 4'b0011, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[13] = '{7'b1100011, 3'b001, 7'h00, 1'b0, 4'b0011, 1'b0, 1'b0, 2'b00, 2'b01};
        vecs[14] = '{7'b1101111, 3'b000, 7'h00, 1'b0, 4'b0010, 1'b1, 1'b1, 2'b01, 2'b01};
        vecs[15] = '{7'b1100111, 3'b000, 7'h00, 1'b0, 4'b0010, 1'b1, 1'b1, 2'b01, 2'b10};
        vecs[16] = '{7'b0110111, 3'b000, 7'h00, 1'b0, 4'b0010, 1'b1, 1'b1, 2'b10, 2'b00};

        ills[0]  = '{7'b0000011, 3'b010, 7'h00, 1'b0, 4'b0, 1'b0, 1'b0, 2'b0, 2'b0};
        ills[1]  = '{7'b0110011, 3'b001, 7'h20, 1'b0, 4'b0, 1'b0, 1'b0, 2'b0, 2'b0};
        ills[2]  = '{7'b1100011, 3'b010, 7'h00, 1'b0, 4'b0, 1'b0, 1'b0, 2'b0, 2'b0};
        ills[3]  = '{7'b0010011, 3'b001, 7'h20, 1'b0, 4'b0, 1'b0, 1'b0, 2'b0, 2'b0};

        rst = 1'b1; imem_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state",    32'(state_dbg), 32'd0);
        chk("rst_imem_req", 32'(imem_req),  32'd0);
        chk("rst_illegal",  32'(illegal),   32'd0);
        chk("rst_timeout",  32'(timeout),   32'd0);
        chk("rst_instret",  instret,        32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            to_execute(vecs[i], 1'b1, (i == 3) ? 3 : 0);
            finish_instr(vecs[i]);
        end

        // Reset while EXECUTE of an ADD: no writes, back to FETCH, counter cleared.
        to_execute(vecs[0], 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstx_regwrite", 32'(regwrite), 32'd0);
        chk("rstx_instret",  instret,       32'(instret_exp));
        @(posedge clk); #2;
        rst = 1'b0;
        instret_exp = 0;
        @(negedge clk);
        chk("rstx_state",   32'(state_dbg), 32'd0);
        chk("rstx_instret", instret,        32'd0);
        @(posedge clk); #2;

        // Reset asserted during WRITEBACK must gate pc_write and regwrite.
        to_execute(vecs[0], 1'b0, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_pc_write", 32'(pc_write), 32'd0);
        chk("rstw_regwrite", 32'(regwrite), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_instret", instret, 32'd0);
        @(posedge clk); #2;

        for (int i = 0; i < 4; i++) begin
            to_execute(ills[i], 1'b0, 0);
            @(negedge clk);
            chk("ill_state",    32'(state_dbg), 32'd4);
            chk("ill_flag",     32'(illegal),   32'd1);
            chk("ill_imem_req", 32'(imem_req),  32'd0);
            @(posedge clk); #2;
            @(negedge clk);
            chk("ill_stays_halt", 32'(state_dbg), 32'd4);
            chk("ill_instret",    instret,        32'(instret_exp));
            @(posedge clk); #2;
            pulse_reset();
            @(negedge clk);
            chk("ill_rst_clear", 32'(illegal), 32'd0);
            @(posedge clk); #2;
        end

        // Fetch timeout with IMEM_TIMEOUT=4, starting from a clean FETCH.
        pulse_reset();
        imem_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("to_pre_state",   32'(state_dbg), 32'd0);
        chk("to_pre_req",     32'(imem_req),  32'd1);
        chk("to_pre_timeout", 32'(timeout),   32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("to_state",   32'(state_dbg), 32'd4);
        chk("to_flag",    32'(timeout),   32'd1);
        chk("to_req_off", 32'(imem_req),  32'd0);
        @(posedge clk); #2;
        pulse_reset();
        @(negedge clk);
        chk("to_rst_state",   32'(state_dbg), 32'd0);
        chk("to_rst_timeout", 32'(timeout),   32'd0);
        chk("to_rst_illegal", 32'(illegal),   32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
